// File: rtl/mod_exp_ctrl.sv
// Sequencer for left-to-right modular exponentiation on an external Montgomery
// product engine: issues square / multiply / convert-out ops and collects the result.
module mod_exp_ctrl #(
  parameter int BITLEN      = 256,
  parameter int LOG_BITLEN  = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [BITLEN-1:0]     e,
  input  logic [LOG_BITLEN:0]   e_len,
  output logic                  mp_start,
  output logic [1:0]            mp_op_code,
  output logic [LOG_BITLEN:0]   mp_count,
  input  logic                  mp_stop,
  input  logic [BITLEN:0]       mp_result,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BITLEN-1:0]     result
);

  localparam int CW = LOG_BITLEN + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] C_BITLEN  = CW'(BITLEN);
  localparam logic [TW-1:0] C_TIMEOUT = TW'(ACK_TIMEOUT);

  localparam logic [1:0] OP_SQR = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_CVT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACK   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t            r_state;
  logic [BITLEN-1:0] r_e;
  logic [CW-1:0]     r_idx;
  logic [TW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic              r_mp_start;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [BITLEN-1:0] r_result;

  logic [CW-1:0]     w_len;
  logic [BITLEN-1:0] w_e_shift;
  logic              w_bit;
  logic [TW-1:0]     w_cnt_inc;
  logic              w_unused_msb;

  // Lengths beyond the operand width are clamped to the full width.
  assign w_len        = (e_len > C_BITLEN) ? C_BITLEN : e_len;
  assign w_e_shift    = r_e >> r_idx;
  assign w_bit        = w_e_shift[0];
  assign w_cnt_inc    = r_cnt + TW'(1);
  assign w_unused_msb = mp_result[BITLEN];

  assign mp_start   = r_mp_start;
  assign mp_op_code = r_op;
  assign mp_count   = C_BITLEN;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign result     = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_e        <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_op       <= OP_SQR;
      r_mp_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
    end else begin
      r_mp_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_e        <= e;
            r_idx      <= (w_len == '0) ? '0 : w_len - CW'(1);
            r_op       <= (w_len == '0) ? OP_CVT : OP_SQR;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_mp_start <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_ACK;
        end
        S_ACK: begin
          if (!mp_stop) begin
            r_state <= S_WAIT;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == C_TIMEOUT) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end
          end
        end
        S_WAIT: begin
          // Engine latency is bounded by design, so no timeout here.
          if (mp_stop) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_op == OP_SQR && w_bit) begin
            r_op       <= OP_MUL;
            r_mp_start <= 1'b1;
            r_state    <= S_ISSUE;
          end else if (r_op == OP_SQR || r_op == OP_MUL) begin
            if (r_idx != '0) begin
              r_idx <= r_idx - CW'(1);
              r_op  <= OP_SQR;
            end else begin
              r_op  <= OP_CVT;
            end
            r_mp_start <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            if (r_op == OP_CVT) begin
              r_result <= mp_result[BITLEN-1:0];
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomized scoreboard bench for mod_exp_ctrl with a toy modular-arithmetic engine.
module tb_mod_exp_ctrl;

  localparam int BITLEN      = 256;
  localparam int LOG_BITLEN  = 8;
  localparam int ACK_TIMEOUT = 8;
  localparam int ENG_LAT     = 5;
  localparam longint unsigned PR = 64'd1000003;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                go = 1'b0;
  logic [BITLEN-1:0]   e = '0;
  logic [LOG_BITLEN:0] e_len = '0;
  logic                mp_start;
  logic [1:0]          mp_op_code;
  logic [LOG_BITLEN:0] mp_count;
  logic                mp_stop = 1'b1;
  logic [BITLEN:0]     mp_result = '0;
  logic                busy;
  logic                done;
  logic                err;
  logic [BITLEN-1:0]   result;

  typedef struct {
    logic              err;
    logic [BITLEN-1:0] res;
  } done_t;

  int    exp_ops[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_start = 0;
  int n_starts = 0;
  int n_done = 0;

  logic [BITLEN-1:0] last_res = '0;
  longint unsigned   eng_x = 1;
  longint unsigned   eng_m = 2;
  bit                eng_dead = 1'b0;

  mod_exp_ctrl #(
    .BITLEN(BITLEN), .LOG_BITLEN(LOG_BITLEN), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .e(e), .e_len(e_len),
    .mp_start(mp_start), .mp_op_code(mp_op_code), .mp_count(mp_count),
    .mp_stop(mp_stop), .mp_result(mp_result),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [BITLEN-1:0] act,
                           input logic [BITLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [BITLEN-1:0] rand_e();
    logic [BITLEN-1:0] v;
    v = '0;
    for (int i = 0; i < BITLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: x0^(2^len) * m^E mod PR, with E = the low len bits of e.
  task automatic model_run(input logic [BITLEN-1:0] ev, input int len_in, input bit dead);
    int              len;
    longint unsigned acc, base, xp, r;
    done_t           d;
    len = (len_in > BITLEN) ? BITLEN : len_in;
    if (dead) begin
      exp_ops.push_back((len == 0) ? 2 : 0);
      d.err = 1'b1;
      d.res = last_res;
    end else begin
      for (int i = len - 1; i >= 0; i--) begin
        exp_ops.push_back(0);
        if (ev[i]) exp_ops.push_back(1);
      end
      exp_ops.push_back(2);
      acc  = 1;
      base = eng_m;
      xp   = eng_x;
      for (int i = 0; i < len; i++) begin
        if (ev[i]) acc = (acc * base) % PR;
        base = (base * base) % PR;
        xp   = (xp * xp) % PR;
      end
      r = (xp * acc) % PR;
      d.err    = 1'b0;
      d.res    = BITLEN'(r);
      last_res = d.res;
    end
    exp_done.push_back(d);
  endtask

  task automatic issue(input logic [BITLEN-1:0] ev, input int len, input longint unsigned x0,
                       input bit dead);
    eng_x    = x0;
    eng_m    = longint'($urandom_range(2, 1000002));
    eng_dead = dead;
    model_run(ev, len, dead);
    e     = ev;
    e_len = len[LOG_BITLEN:0];
    go    = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input bit spur);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      go = spur ? (busy && ($urandom_range(0, 3) == 0)) : 1'b0;
      n++;
    end
    go = 1'b0;
    if (n >= budget) fail_now("wait_idle_timeout", "run did not finish within budget");
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done !== 1'b1) fail_now("wait_done_timeout", "done not seen within budget");
  endtask

  task automatic run(input logic [BITLEN-1:0] ev, input int len, input longint unsigned x0,
                     input bit dead, input bit spur, input int budget);
    issue(ev, len, x0, dead);
    @(negedge clk); #1;
    go = 1'b0;
    check_int("busy_after_go", int'(busy), 1);
    check_int("err_cleared_on_go", int'(err), 0);
    wait_idle(budget, spur);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_err"}, int'(err), 0);
    check_int({tag, "_mp_start"}, int'(mp_start), 0);
    check_int({tag, "_op"}, int'(mp_op_code), 0);
    check_vec({tag, "_result"}, result, '0);
  endtask

  // Toy engine: holds x, applies the requested op after ENG_LAT cycles.
  initial begin : engine
    bit active;
    int left;
    int op;
    active = 1'b0;
    left   = 0;
    op     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mp_stop = 1'b1;
        active  = 1'b0;
      end else if (active) begin
        if (left > 0) begin
          left--;
        end else begin
          check_int("op_hold", int'(mp_op_code), op);
          case (op)
            0:       eng_x = (eng_x * eng_x) % PR;
            1:       eng_x = (eng_x * eng_m) % PR;
            default: ;
          endcase
          mp_result = (BITLEN+1)'(eng_x);
          mp_stop   = 1'b1;
          active    = 1'b0;
        end
      end else if (mp_start && !eng_dead) begin
        op      = int'(mp_op_code);
        mp_stop = 1'b0;
        active  = 1'b1;
        left    = ENG_LAT - 1;
      end
    end
  end

  initial begin : monitor
    done_t d;
    int    eo;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (mp_start) begin
          n_starts++;
          last_start = cyc;
          if (exp_ops.size() == 0) begin
            fail_now("unexpected_start", $sformatf("got mp_start op %0d expected none", mp_op_code));
          end else begin
            eo = exp_ops.pop_front();
            check_int("op_code", int'(mp_op_code), eo);
          end
        end
        if (done) begin
          n_done++;
          if (exp_done.size() == 0) begin
            fail_now("unexpected_done", "got done=1 expected no done");
          end else begin
            d = exp_done.pop_front();
            check_int("done_err", int'(err), int'(d.err));
            check_vec("done_result", result, d.res);
            check_int("done_busy_low", int'(busy), 0);
            if (d.err) check_int("timeout_latency", cyc - last_start, ACK_TIMEOUT + 1);
            else       check_int("ops_consumed", exp_ops.size(), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [BITLEN-1:0] ev;
    int                n0, d0, n;
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    check_int("mp_count", int'(mp_count), BITLEN);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed 1011 exponent: 0,1,0,0,1,0,1,2.
    n0 = n_starts; d0 = n_done;
    run(256'hB, 4, longint'($urandom_range(1, 1000002)), 1'b0, 1'b0, 2000);
    check_int("e1011_starts", n_starts - n0, 8);
    check_int("e1011_dones", n_done - d0, 1);
    check_int("e1011_err", int'(err), 0);

    // Zero length: convert-out only.
    n0 = n_starts;
    run(rand_e(), 0, 64'h5A, 1'b0, 1'b0, 2000);
    check_int("len0_starts", n_starts - n0, 1);
    check_vec("len0_result", result, 256'h5A);

    // Engine never acknowledges.
    run(rand_e(), 5, 64'd3, 1'b1, 1'b0, 2000);
    repeat (3) begin
      @(negedge clk); #1;
      check_int("err_hold", int'(err), 1);
    end
    check_vec("timeout_result_kept", result, 256'h5A);

    // Random runs with go pulsed while busy.
    for (int k = 0; k < 6; k++) begin
      n0 = n_starts;
      ev = rand_e();
      n  = $urandom_range(0, 12);
      run(ev, n, longint'($urandom_range(1, 1000002)), 1'b0, 1'b1, 3000);
      check_int("rand_op_count", n_starts - n0, n + $countones(ev & ((256'h1 << n) - 256'h1)) + 1);
    end

    // go only in the FIN cycle is ignored.
    issue(rand_e(), 3, 64'd7, 1'b0);
    @(negedge clk); #1 go = 1'b0;
    wait_done(3000);
    go = 1'b1;
    @(negedge clk); #1 go = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check_int("fin_go_ignored", int'(busy), 0);
    end

    // go held from FIN into the following cycle is accepted.
    issue(rand_e(), 3, 64'd11, 1'b0);
    @(negedge clk); #1 go = 1'b0;
    wait_done(3000);
    issue(rand_e(), 4, 64'd13, 1'b0);
    @(negedge clk); #1;
    check_int("idle_after_fin", int'(busy), 0);
    @(negedge clk); #1 go = 1'b0;
    check_int("go_after_fin_accepted", int'(busy), 1);
    wait_idle(3000, 1'b0);

    // Asynchronous reset during WAIT of the third op.
    n0 = n_starts;
    issue(256'hF, 4, 64'd5, 1'b0);
    @(negedge clk); #1 go = 1'b0;
    n = 0;
    while (n_starts < n0 + 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_starts < n0 + 3) fail_now("third_op_timeout", "third mp_start not seen");
    @(negedge clk);
    @(negedge clk);
    #2;
    check_int("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_ops.delete();
    exp_done.delete();
    last_res = '0;
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    d0 = n_done;
    repeat (10) @(negedge clk);
    #1;
    check_int("no_done_after_reset", n_done - d0, 0);
    n0 = n_starts;
    run(256'hF, 4, 64'd9, 1'b0, 1'b0, 2000);
    check_int("post_reset_starts", n_starts - n0, 9);

    // Over-long length clamps to BITLEN.
    n0 = n_starts;
    ev = rand_e();
    run(ev, 300, longint'($urandom_range(1, 1000002)), 1'b0, 1'b0, 20000);
    check_int("len300_op_count", n_starts - n0, BITLEN + $countones(ev) + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
